// File: rtl/femto_bus_fabric.sv
`timescale 1ns/1ps
// Table-driven page decoder and wait-state router between the FemtoRV32 memory port and N slaves,
// with a per-access timeout watchdog and sticky capture of timeouts and unmapped accesses.
module femto_bus_fabric #(
  parameter int unsigned              N_SLAVES            = 8,
  parameter logic [16*N_SLAVES-1:0]   SLAVE_PAGES         = {16'h0045, 16'h0044, 16'h0043, 16'h0042,
                                                             16'h0041, 16'h0040, 16'h0001, 16'h0000},
  parameter int unsigned              DEFAULT_SLAVE       = 0,
  parameter bit                       UNMAPPED_TO_DEFAULT = 1'b1,
  parameter int unsigned              TIMEOUT_CYCLES      = 1024,
  parameter logic [31:0]              ERR_DATA            = 32'hDEADBEEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [31:0]               cpu_addr,
  input  logic                      cpu_rstrb,
  input  logic [3:0]                cpu_wmask,
  input  logic [31:0]               cpu_wdata,
  output logic [31:0]               cpu_rdata,
  output logic                      cpu_rbusy,
  output logic                      cpu_wbusy,
  output logic [31:0]               slv_wdata,
  output logic [N_SLAVES-1:0]       slv_rd,
  output logic [N_SLAVES-1:0]       slv_wr,
  input  logic [32*N_SLAVES-1:0]    slv_rdata,
  input  logic [N_SLAVES-1:0]       slv_rbusy,
  input  logic [N_SLAVES-1:0]       slv_wbusy,
  input  logic                      fault_clear,
  output logic                      fault_valid,
  output logic [31:0]               fault_addr,
  output logic                      fault_is_write,
  output logic [7:0]                fault_count
);

  localparam int unsigned IW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_WAIT = 2'd1;
  localparam logic [1:0] S_WR_WAIT = 2'd2;

  logic [1:0]    r_state;
  logic [CW-1:0] r_to_cnt;
  logic [IW-1:0] r_ridx;
  logic          r_err_rd;
  logic [31:0]   r_addr;
  logic          r_fault_valid;
  logic [31:0]   r_fault_addr;
  logic          r_fault_is_write;
  logic [7:0]    r_fault_count;

  logic          w_wr;
  logic          w_rd;
  logic          w_req;
  logic          w_idle;
  logic          w_hit_any;
  logic [IW-1:0] w_idx;
  logic          w_mapped;
  logic          w_accept;
  logic          w_unmapped;
  logic [31:0]   w_rdata_sel;
  logic          w_rbusy_sel;
  logic          w_wbusy_sel;
  logic          w_busy_sel;
  logic          w_to_hit;
  logic          w_timeout;
  logic          w_fault_ev;
  logic [31:0]   w_fault_addr;
  logic          w_fault_wr;

  assign w_wr   = |cpu_wmask;
  assign w_rd   = cpu_rstrb & ~w_wr;
  assign w_req  = w_rd | w_wr;
  assign w_idle = (r_state == S_IDLE);

  // Ascending scan with a found flag gives lowest-index priority on duplicate pages.
  always_comb begin
    w_hit_any = 1'b0;
    w_idx     = IW'(DEFAULT_SLAVE);
    for (int unsigned i = 0; i < N_SLAVES; i++) begin
      if (!w_hit_any && (cpu_addr[31:16] == SLAVE_PAGES[16*i +: 16])) begin
        w_hit_any = 1'b1;
        w_idx     = IW'(i);
      end
    end
  end

  assign w_mapped   = w_hit_any | UNMAPPED_TO_DEFAULT;
  assign w_accept   = w_idle & w_req & w_mapped;
  assign w_unmapped = w_idle & w_req & ~w_mapped;

  always_comb begin
    slv_rd = '0;
    slv_wr = '0;
    for (int unsigned i = 0; i < N_SLAVES; i++) begin
      slv_rd[i] = w_accept & w_rd & (w_idx == IW'(i));
      slv_wr[i] = w_accept & w_wr & (w_idx == IW'(i));
    end
  end

  always_comb begin
    w_rdata_sel = '0;
    w_rbusy_sel = 1'b0;
    w_wbusy_sel = 1'b0;
    for (int unsigned i = 0; i < N_SLAVES; i++) begin
      if (r_ridx == IW'(i)) begin
        w_rdata_sel = slv_rdata[32*i +: 32];
        w_rbusy_sel = slv_rbusy[i];
        w_wbusy_sel = slv_wbusy[i];
      end
    end
  end

  assign w_busy_sel = w_rbusy_sel | w_wbusy_sel;
  assign w_to_hit   = (r_to_cnt == CW'(TIMEOUT_CYCLES));
  assign w_timeout  = ~w_idle & w_to_hit;

  assign cpu_rbusy  = (r_state == S_RD_WAIT) & w_rbusy_sel & ~w_to_hit;
  assign cpu_wbusy  = (r_state == S_WR_WAIT) & w_wbusy_sel & ~w_to_hit;
  assign cpu_rdata  = r_err_rd ? ERR_DATA : w_rdata_sel;
  assign slv_wdata  = cpu_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_to_cnt <= '0;
      r_ridx   <= IW'(DEFAULT_SLAVE);
      r_err_rd <= 1'b0;
      r_addr   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state  <= w_wr ? S_WR_WAIT : S_RD_WAIT;
            r_to_cnt <= '0;
            r_ridx   <= w_idx;
            r_addr   <= cpu_addr;
            if (w_rd) r_err_rd <= 1'b0;
          end else if (w_unmapped && w_rd) begin
            r_err_rd <= 1'b1;
          end
        end
        S_RD_WAIT, S_WR_WAIT: begin
          if (w_to_hit || !w_busy_sel) begin
            r_state <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
          if (w_to_hit && (r_state == S_RD_WAIT)) r_err_rd <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_fault_ev   = w_timeout | w_unmapped;
  assign w_fault_addr = w_timeout ? r_addr : cpu_addr;
  assign w_fault_wr   = w_timeout ? (r_state == S_WR_WAIT) : w_wr;

  // A same-cycle clear is folded into the capture so the new event starts a fresh record.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault_valid    <= 1'b0;
      r_fault_addr     <= '0;
      r_fault_is_write <= 1'b0;
      r_fault_count    <= '0;
    end else if (w_fault_ev) begin
      if (!r_fault_valid || fault_clear) begin
        r_fault_valid    <= 1'b1;
        r_fault_addr     <= w_fault_addr;
        r_fault_is_write <= w_fault_wr;
        r_fault_count    <= 8'd1;
      end else if (r_fault_count != 8'hFF) begin
        r_fault_count <= r_fault_count + 8'd1;
      end
    end else if (fault_clear) begin
      r_fault_valid    <= 1'b0;
      r_fault_addr     <= '0;
      r_fault_is_write <= 1'b0;
      r_fault_count    <= '0;
    end
  end

  assign fault_valid    = r_fault_valid;
  assign fault_addr     = r_fault_addr;
  assign fault_is_write = r_fault_is_write;
  assign fault_count    = r_fault_count;

endmodule

// File: doc/femto_bus_fabric.md
Name: femto_bus_fabric

Overview:
Parametrised memory-mapped interconnect between the FemtoRV32 core and N peripheral slaves. It replaces the fixed 7-way chip-select decoder and read mux with a table-driven page decoder, a latched read-return index and per-slave busy routing. It adds a bus-timeout watchdog and sticky fault capture. It sits directly between the CPU memory port and the SPI flash, SPI RAM, UART and other peripherals in the SoC top.

Parameters:
N_SLAVES, 8, number of slave ports (1..16)
SLAVE_PAGES, {16'h0000,16'h0001,16'h0040,16'h0041,16'h0042,16'h0043,16'h0044,16'h0045}, packed N_SLAVES x 16-bit values matched against cpu_addr[31:16]; slot i is at bits [16i+15:16i]
DEFAULT_SLAVE, 0, slave index used for unmatched pages when UNMAPPED_TO_DEFAULT=1
UNMAPPED_TO_DEFAULT, 1, 1 = route unmatched pages to DEFAULT_SLAVE; 0 = treat them as faults
TIMEOUT_CYCLES, 1024, maximum number of busy cycles before the fabric forces completion
ERR_DATA, 32'hDEADBEEF, read data returned on a timeout or an unmapped read

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cpu_addr  in  32  CPU byte address
cpu_rstrb  in  1  CPU read strobe, one cycle wide
cpu_wmask  in  4  CPU byte write mask; nonzero means a write
cpu_wdata  in  32  CPU write data, passed through unchanged to slv_wdata
cpu_rdata  out  32  read data returned to the CPU
cpu_rbusy  out  1  read stall to the CPU
cpu_wbusy  out  1  write stall to the CPU
slv_wdata  out  32  write data broadcast to all slaves
slv_rd  out  N_SLAVES  per-slave read strobe
slv_wr  out  N_SLAVES  per-slave write strobe
slv_rdata  in  32*N_SLAVES  packed slave read data; slot i is at [32i+31:32i]
slv_rbusy  in  N_SLAVES  per-slave read busy
slv_wbusy  in  N_SLAVES  per-slave write busy
fault_clear  in  1  synchronous clear for the fault registers
fault_valid  out  1  sticky fault flag
fault_addr  out  32  address of the first fault since the last clear
fault_is_write  out  1  1 = the captured fault was a write
fault_count  out  8  saturating fault counter

Behaviour:
- Decode (combinational): hit[i] = (cpu_addr[31:16] == SLAVE_PAGES[i]).
  - Lowest matching index wins on duplicate pages.
  - No match: idx = DEFAULT_SLAVE if UNMAPPED_TO_DEFAULT=1; otherwise the access is unmapped.
- Strobes (combinational, IDLE state only):
  - slv_rd[idx] = cpu_rstrb & ~wr.
  - slv_wr[idx] = wr, where wr = |cpu_wmask.
  - Write has priority if cpu_rstrb and wr occur in the same cycle; the read is dropped.
  - Unmapped accesses strobe no slave.
- FSM states: IDLE, RD_WAIT, WR_WAIT.
  - IDLE -> RD_WAIT on a mapped read.
  - IDLE -> WR_WAIT on a mapped write.
  - RD_WAIT/WR_WAIT -> IDLE on the first clock edge where busy_sel==0, or on a timeout.
  - busy_sel = slv_rbusy[ridx] or slv_wbusy[ridx].
  - Each wait state lasts at least one cycle.
  - Strobes arriving in RD_WAIT/WR_WAIT are ignored; no slave strobe is issued.
- ridx register: loaded with idx on every mapped read or write accepted in IDLE. Reset value is DEFAULT_SLAVE.
- cpu_rdata:
  - Normally slv_rdata[ridx], and it holds after the read completes until the next accepted access.
  - ERR_DATA while the err_rd flag is set. err_rd is set by a timed-out read or an unmapped read, and cleared at the next accepted read.
- Busy signals:
  - cpu_rbusy = (state==RD_WAIT) & slv_rbusy[ridx] & ~to_hit.
  - cpu_wbusy = (state==WR_WAIT) & slv_wbusy[ridx] & ~to_hit.
  - Slave contract: a slave must raise its busy in the cycle after its strobe if it is not ready.
- Timeout:
  - Counter width is clog2(TIMEOUT_CYCLES+1). It clears on entry to a wait state and increments each wait cycle in which busy_sel==1.
  - to_hit = (count == TIMEOUT_CYCLES). When it is set, the busy outputs drop in that cycle and the FSM returns to IDLE on the next edge.
- Unmapped access (UNMAPPED_TO_DEFAULT=0): completes with zero wait; a read returns ERR_DATA from the next cycle onward.
- Fault capture: a fault event is a timeout or an unmapped access.
  - On the first event while fault_valid==0: fault_valid=1, fault_addr=cpu_addr (or the latched address for a timeout), and fault_is_write is captured.
  - Later events update only fault_count, which saturates at 255.
  - fault_clear zeroes all four fault outputs. If a fault event and fault_clear occur in the same cycle, the event wins: valid=1 and count=1.
- Reset (async, any state, including mid-transaction):
  - FSM goes to IDLE; timeout counter is 0; ridx=DEFAULT_SLAVE; err_rd=0.
  - cpu_rbusy=0, cpu_wbusy=0.
  - fault_valid=0, fault_addr=0, fault_is_write=0, fault_count=0.
  - cpu_rdata = slv_rdata[DEFAULT_SLAVE].

Test Plan:
- Read at 0x00400004 (UART, slot 2) with slv_rbusy[2] held for 3 cycles -> slv_rd[2] pulses one cycle; cpu_rbusy high for exactly 3 cycles; cpu_rdata = slot 2 data and holds afterwards.
- Write wmask=4'hF to 0x00010010 with slv_wbusy[1] held for 5 cycles -> only slv_wr[1] pulses; cpu_wbusy high for 5 cycles; slv_wdata = cpu_wdata.
- TIMEOUT_CYCLES=16, read slot 0 with rbusy stuck at 1 -> cpu_rbusy drops after 16 cycles; cpu_rdata=32'hDEADBEEF; fault_valid=1; fault_addr = read address; fault_is_write=0; fault_count=1.
- UNMAPPED_TO_DEFAULT=0, read 0x12340000 -> no slv_rd strobe; cpu_rbusy=0; cpu_rdata=ERR_DATA; then a second unmapped write -> fault_count=2 and fault_addr unchanged.
- Fault event coincident with fault_clear -> fault_valid=1, fault_count=1; then 300 fault events -> fault_count saturates at 255.
- Assert rst_n=0 mid-RD_WAIT -> cpu_rbusy=0 immediately, all fault outputs 0; the next read is accepted normally.
